mem_wb_pipe: RTL

//  EX/MEM and MEM/WB pipeline registers of the 4-bit-opcode pipeline. Captures EX results,

---
 rtl/mem_wb_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers: drives the data-memory port in MEM,
// merges load data into WB, publishes forwarding fields and counts retirements.
module mem_wb_pipe #(
    parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
    parameter int unsigned bitwidth            = 32,
    parameter logic [3:0]  LW_OPCODE           = 4'b0001,
    parameter logic [3:0]  BUBBLE_OPCODE       = 4'b0010,
    parameter int unsigned CNT_W               = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           ex_valid,
    input  logic [3:0]                     ex_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_index,
    input  logic [bitwidth-1:0]            ex_data,
    input  logic [bitwidth-1:0]            ex_store_data,
    input  logic [bitwidth-1:0]            mem_rdata,
    output logic [bitwidth-1:0]            mem_addr,
    output logic [bitwidth-1:0]            mem_wdata,
    output logic                           mem_we,
    output logic [3:0]                     MEM_opcode,
    output logic [REG_INDEX_BIT_WIDTH-1:0] MEM_index,
    output logic [bitwidth-1:0]            MEM_data,
    output logic                           mem_is_load,
    output logic [3:0]                     WB_opcode,
    output logic [REG_INDEX_BIT_WIDTH-1:0] WB_index,
    output logic [bitwidth-1:0]            WB_data,
    output logic                           wb_we,
    output logic [CNT_W-1:0]               retire_count
);

    localparam logic [3:0] SW_OPCODE     = 4'b0011;
    localparam logic [3:0] BRANCH_OPCODE = 4'b0010;

    logic                           r_mem_valid;
    logic [3:0]                     r_mem_opcode;
    logic [REG_INDEX_BIT_WIDTH-1:0] r_mem_index;
    logic [bitwidth-1:0]            r_mem_data;
    logic [bitwidth-1:0]            r_mem_wdata;
    logic                           r_wb_valid;
    logic [3:0]                     r_wb_opcode;
    logic [REG_INDEX_BIT_WIDTH-1:0] r_wb_index;
    logic [bitwidth-1:0]            r_wb_data;
    logic [CNT_W-1:0]               r_retire_count;

    logic                           w_mem_valid;
    logic [3:0]                     w_mem_opcode;
    logic [REG_INDEX_BIT_WIDTH-1:0] w_mem_index;
    logic [bitwidth-1:0]            w_mem_data;
    logic [bitwidth-1:0]            w_mem_wdata;
    logic                           w_wb_valid;
    logic [3:0]                     w_wb_opcode;
    logic [REG_INDEX_BIT_WIDTH-1:0] w_wb_index;
    logic [bitwidth-1:0]            w_wb_data;
    logic [CNT_W-1:0]               w_retire_count;
    logic                           w_advance;

    // Next-state: flush beats stall, and WB always takes MEM when anything advances.
    always_comb begin
        w_mem_valid    = r_mem_valid;
        w_mem_opcode   = r_mem_opcode;
        w_mem_index    = r_mem_index;
        w_mem_data     = r_mem_data;
        w_mem_wdata    = r_mem_wdata;
        w_wb_valid     = r_wb_valid;
        w_wb_opcode    = r_wb_opcode;
        w_wb_index     = r_wb_index;
        w_wb_data      = r_wb_data;
        w_retire_count = r_retire_count;
        w_advance      = flush || !stall;

        if (w_advance) begin
            w_wb_valid  = r_mem_valid;
            w_wb_opcode = r_mem_opcode;
            w_wb_index  = r_mem_index;
            w_wb_data   = (r_mem_opcode == LW_OPCODE) ? mem_rdata : r_mem_data;
            if (flush || !ex_valid) begin
                w_mem_valid  = 1'b0;
                w_mem_opcode = BUBBLE_OPCODE;
                w_mem_index  = '0;
                w_mem_data   = '0;
                w_mem_wdata  = '0;
            end else begin
                w_mem_valid  = 1'b1;
                w_mem_opcode = ex_opcode;
                w_mem_index  = ex_index;
                w_mem_data   = ex_data;
                w_mem_wdata  = ex_store_data;
            end
            if (r_wb_valid) begin
                w_retire_count = r_retire_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_valid    <= 1'b0;
            r_mem_opcode   <= BUBBLE_OPCODE;
            r_mem_index    <= '0;
            r_mem_data     <= '0;
            r_mem_wdata    <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_opcode    <= BUBBLE_OPCODE;
            r_wb_index     <= '0;
            r_wb_data      <= '0;
            r_retire_count <= '0;
        end else begin
            r_mem_valid    <= w_mem_valid;
            r_mem_opcode   <= w_mem_opcode;
            r_mem_index    <= w_mem_index;
            r_mem_data     <= w_mem_data;
            r_mem_wdata    <= w_mem_wdata;
            r_wb_valid     <= w_wb_valid;
            r_wb_opcode    <= w_wb_opcode;
            r_wb_index     <= w_wb_index;
            r_wb_data      <= w_wb_data;
            r_retire_count <= w_retire_count;
        end
    end

    // Strobes decoded from stage registers; a stall masks the store strobe.
    assign mem_we       = r_mem_valid && (r_mem_opcode == SW_OPCODE) && !stall;
    assign mem_is_load  = r_mem_valid && (r_mem_opcode == LW_OPCODE);
    assign wb_we        = r_wb_valid && (r_wb_opcode != BRANCH_OPCODE) && (r_wb_opcode != SW_OPCODE);

    assign mem_addr     = r_mem_data;
    assign mem_wdata    = r_mem_wdata;
    assign MEM_opcode   = r_mem_opcode;
    assign MEM_index    = r_mem_index;
    assign MEM_data     = r_mem_data;
    assign WB_opcode    = r_wb_opcode;
    assign WB_index     = r_wb_index;
    assign WB_data      = r_wb_data;
    assign retire_count = r_retire_count;

endmodule
